// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the decode-stage hazard scheduler: Tuse/Tnew codes,
// mult/div sequencer states, default latencies and the per-operand hazard test.
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_NOW  = 2'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

    // A source is blocked when a younger-stage producer will not have its
    // result ready by the time D needs it; Tnew==0 falls to forwarding.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       e_we,
        input logic [4:0] e_addr,
        input logic [1:0] e_tnew,
        input logic       m_we,
        input logic [4:0] m_addr,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = e_we && (e_addr == src) && (tuse < e_tnew);
        m_hit = m_we && (m_addr == src) && (tuse < m_tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// Mult/div occupancy sequencer: counts down the unit latency after an issue in E
// and reports MD_Busy combinationally so the very next D instruction sees it.
module hazard_stall_ctrl_md_busy_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_is_div_i,
    output logic md_busy_o
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start_i) begin
                        state_q <= md_is_div_i ? MD_DIV : MD_MULT;
                        cnt_q   <= md_is_div_i ? CNT_W'(DIV_CYCLES - 1)
                                               : CNT_W'(MULT_CYCLES - 1);
                    end
                end
                MD_MULT, MD_DIV: begin
                    // A new start here is impossible: D is held while busy.
                    if (cnt_q == '0) begin
                        state_q <= MD_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign md_busy_o = md_start_i | (state_q != MD_IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall controller (Tuse/Tnew compare plus mult/div busy stall).
// Optional HAZARD_STALL_STATS_EN adds 32-bit stall and MD-stall cycle counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_Rs,
    input  logic [4:0]  D_Rt,
    input  logic [1:0]  D_TuseRs,
    input  logic [1:0]  D_TuseRt,
    input  logic        D_IsMD,
    input  logic        E_GRFWE,
    input  logic [4:0]  E_Addr,
    input  logic [1:0]  E_Tnew,
    input  logic        M_GRFWE,
    input  logic [4:0]  M_Addr,
    input  logic [1:0]  M_Tnew,
    input  logic        E_MDStart,
    input  logic        E_MDIsDiv,
`ifdef HAZARD_STALL_STATS_EN
    output logic [31:0] StallCycles,
    output logic [31:0] MDStallCycles,
`endif
    output logic        Stall,
    output logic        PC_En,
    output logic        FD_En,
    output logic        DE_Flush,
    output logic        MD_Busy
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    hazard_stall_ctrl_md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_seq (
        .clk         (clk),
        .reset       (reset),
        .md_start_i  (E_MDStart),
        .md_is_div_i (E_MDIsDiv),
        .md_busy_o   (MD_Busy)
    );

    assign stall_rs = src_hazard(D_Rs, D_TuseRs, E_GRFWE, E_Addr, E_Tnew,
                                 M_GRFWE, M_Addr, M_Tnew);
    assign stall_rt = src_hazard(D_Rt, D_TuseRt, E_GRFWE, E_Addr, E_Tnew,
                                 M_GRFWE, M_Addr, M_Tnew);
    assign stall_md = D_IsMD & MD_Busy;

    // Nothing is frozen while reset is held, whatever the stage inputs show.
    assign Stall    = ~reset & (stall_rs | stall_rt | stall_md);
    assign PC_En    = ~Stall;
    assign FD_En    = ~Stall;
    assign DE_Flush = Stall;

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] md_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            if (Stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (stall_md) begin
                md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
            end
        end
    end

    assign StallCycles   = stall_cnt_q;
    assign MDStallCycles = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a table of register-hazard vectors
// plus hand-written mult/div, reset-abort and (optional) statistics sequences.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_Rs, D_Rt;
    logic [1:0]  D_TuseRs, D_TuseRt;
    logic        D_IsMD;
    logic        E_GRFWE;
    logic [4:0]  E_Addr;
    logic [1:0]  E_Tnew;
    logic        M_GRFWE;
    logic [4:0]  M_Addr;
    logic [1:0]  M_Tnew;
    logic        E_MDStart, E_MDIsDiv;
    logic        Stall, PC_En, FD_En, DE_Flush, MD_Busy;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] StallCycles, MDStallCycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hazard_stall_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .D_Rs          (D_Rs),
        .D_Rt          (D_Rt),
        .D_TuseRs      (D_TuseRs),
        .D_TuseRt      (D_TuseRt),
        .D_IsMD        (D_IsMD),
        .E_GRFWE       (E_GRFWE),
        .E_Addr        (E_Addr),
        .E_Tnew        (E_Tnew),
        .M_GRFWE       (M_GRFWE),
        .M_Addr        (M_Addr),
        .M_Tnew        (M_Tnew),
        .E_MDStart     (E_MDStart),
        .E_MDIsDiv     (E_MDIsDiv),
`ifdef HAZARD_STALL_STATS_EN
        .StallCycles   (StallCycles),
        .MDStallCycles (MDStallCycles),
`endif
        .Stall         (Stall),
        .PC_En         (PC_En),
        .FD_En         (FD_En),
        .DE_Flush      (DE_Flush),
        .MD_Busy       (MD_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       e_we;
        logic [4:0] e_addr;
        logic [1:0] e_tnew;
        logic       m_we;
        logic [4:0] m_addr;
        logic [1:0] m_tnew;
        logic       is_md;
        logic       exp_stall;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [1:0] trs, input logic [1:0] trt,
                                input logic ewe, input logic [4:0] ea, input logic [1:0] etn,
                                input logic mwe, input logic [4:0] ma, input logic [1:0] mtn,
                                input logic md, input logic exp_s);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.tuse_rs = trs; v.tuse_rt = trt;
        v.e_we = ewe; v.e_addr = ea; v.e_tnew = etn;
        v.m_we = mwe; v.m_addr = ma; v.m_tnew = mtn;
        v.is_md = md; v.exp_stall = exp_s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_outs(input string nm, input logic exp_stall, input logic exp_busy);
        chk({nm, ".Stall"},    32'(Stall),    32'(exp_stall));
        chk({nm, ".PC_En"},    32'(PC_En),    32'(!exp_stall));
        chk({nm, ".FD_En"},    32'(FD_En),    32'(!exp_stall));
        chk({nm, ".DE_Flush"}, 32'(DE_Flush), 32'(exp_stall));
        chk({nm, ".MD_Busy"},  32'(MD_Busy),  32'(exp_busy));
        $display("[TB] %-14s stall=%0b busy=%0b (exp %0b/%0b)",
                 nm, Stall, MD_Busy, exp_stall, exp_busy);
    endtask

    task automatic idle_inputs();
        D_Rs = 5'd0; D_Rt = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3; D_IsMD = 1'b0;
        E_GRFWE = 1'b0; E_Addr = 5'd0; E_Tnew = 2'd0;
        M_GRFWE = 1'b0; M_Addr = 5'd0; M_Tnew = 2'd0;
        E_MDStart = 1'b0; E_MDIsDiv = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        D_Rs = v.rs; D_Rt = v.rt; D_TuseRs = v.tuse_rs; D_TuseRt = v.tuse_rt;
        D_IsMD = v.is_md;
        E_GRFWE = v.e_we; E_Addr = v.e_addr; E_Tnew = v.e_tnew;
        M_GRFWE = v.m_we; M_Addr = v.m_addr; M_Tnew = v.m_tnew;
        E_MDStart = 1'b0; E_MDIsDiv = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // Issue a mult/div in E with D holding (is_md) instruction; check the busy window.
    task automatic md_seq(input string nm, input logic is_div, input logic is_md, input int busy_len);
        for (int i = 0; i <= busy_len; i++) begin
            next_cycle();
            idle_inputs();
            D_IsMD    = is_md;
            E_MDStart = (i == 0);
            E_MDIsDiv = is_div;
            if (i == 2) begin
                // A start while busy must be ignored.
                E_MDStart = 1'b1;
                E_MDIsDiv = ~is_div;
            end
            #2;
            chk_outs($sformatf("%s[%0d]", nm, i), is_md && (i < busy_len), i < busy_len);
        end
    endtask

    initial begin
        vecs[0]  = mk("none",      0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        vecs[1]  = mk("lu_E",      8, 0, 1, 3, 1, 8, 2, 0, 0, 0, 0, 1'b1);
        vecs[2]  = mk("lu_M_tn1",  8, 0, 1, 3, 0, 0, 0, 1, 8, 1, 0, 1'b0);
        vecs[3]  = mk("br_M_tn1",  8, 0, 0, 3, 0, 0, 0, 1, 8, 1, 0, 1'b1);
        vecs[4]  = mk("br_E_alu",  5, 0, 0, 3, 1, 5, 1, 0, 0, 0, 0, 1'b1);
        vecs[5]  = mk("br_r0",     0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 1'b0);
        vecs[6]  = mk("tuse_none", 5, 0, 3, 3, 1, 5, 1, 0, 0, 0, 0, 1'b0);
        vecs[7]  = mk("tnew0",     5, 0, 0, 3, 1, 5, 0, 1, 5, 0, 0, 1'b0);
        vecs[8]  = mk("rt_E",      0, 7, 3, 1, 1, 7, 2, 0, 0, 0, 0, 1'b1);
        vecs[9]  = mk("rt_M",      0, 7, 3, 0, 0, 0, 0, 1, 7, 1, 0, 1'b1);
        vecs[10] = mk("e_we0",     5, 0, 0, 3, 0, 5, 1, 0, 0, 0, 0, 1'b0);
        vecs[11] = mk("addr_miss", 5, 6, 0, 0, 1, 9, 2, 1, 4, 1, 0, 1'b0);
        vecs[12] = mk("md_idle",   0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 1'b0);
        vecs[13] = mk("rt_r0",     0, 0, 3, 0, 1, 0, 2, 1, 0, 1, 0, 1'b0);
        vecs[14] = mk("rs_rt_both",5, 7, 0, 0, 1, 5, 1, 1, 7, 1, 0, 1'b1);

        reset = 1'b1;
        idle_inputs();

        // Reset dominates even with a hazard presented.
        next_cycle();
        drive(vecs[1]);
        #2;
        chk_outs("reset_hold", 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #2;
        chk_outs("post_reset", 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            drive(vecs[i]);
            #2;
            chk_outs(vecs[i].name, vecs[i].exp_stall, 1'b0);
        end

        // Load feeding a branch: stalls while lw in E (Tnew 2) and in M (Tnew 1).
        next_cycle(); drive(vecs[3]); E_GRFWE = 1'b1; E_Addr = 5'd8; E_Tnew = 2'd2;
        M_GRFWE = 1'b0; #2; chk_outs("lu_seq0", 1'b1, 1'b0);
        next_cycle(); drive(vecs[3]); #2; chk_outs("lu_seq1", 1'b1, 1'b0);
        next_cycle(); drive(vecs[3]); M_Tnew = 2'd0; #2; chk_outs("lu_seq2", 1'b0, 1'b0);

        md_seq("mult_mflo", 1'b0, 1'b1, 6);
        md_seq("div_nonmd", 1'b1, 1'b0, 11);

        // Reset on the third busy cycle of a div aborts it.
        for (int i = 0; i < 2; i++) begin
            next_cycle(); idle_inputs(); D_IsMD = 1'b1;
            E_MDStart = (i == 0); E_MDIsDiv = 1'b1;
            #2; chk_outs($sformatf("div_abort[%0d]", i), 1'b1, 1'b1);
        end
        next_cycle(); idle_inputs(); D_IsMD = 1'b1; reset = 1'b1;
        #2; chk_outs("div_abort_rst", 1'b0, 1'b1);
        next_cycle(); reset = 1'b0; idle_inputs(); D_IsMD = 1'b1;
        #2; chk_outs("div_abort_mflo", 1'b0, 1'b0);

`ifdef HAZARD_STALL_STATS_EN
        do_reset();
        #2;
        chk("stats_rst.StallCycles",   StallCycles,   32'd0);
        chk("stats_rst.MDStallCycles", MDStallCycles, 32'd0);
        next_cycle(); drive(vecs[3]); E_GRFWE = 1'b1; E_Addr = 5'd8; E_Tnew = 2'd2; M_GRFWE = 1'b0;
        next_cycle(); drive(vecs[3]);
        next_cycle(); drive(vecs[3]); M_Tnew = 2'd0;
        md_seq("stats_mult", 1'b0, 1'b1, 6);
        next_cycle(); idle_inputs(); #2;
        chk("stats.StallCycles",   StallCycles,   32'd8);
        chk("stats.MDStallCycles", MDStallCycles, 32'd6);
        $display("[TB] stats StallCycles=%0d MDStallCycles=%0d", StallCycles, MDStallCycles);
        do_reset();
        #2;
        chk("stats_clr.StallCycles",   StallCycles,   32'd0);
        chk("stats_clr.MDStallCycles", MDStallCycles, 32'd0);
`endif

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
